seg_scan_display: RTL and testbench

Parametrised multiplexed 7-segment scanner driving DIGITS common-select digits from packed 4-bit digit codes. Successor to the fixed 3-digit decimal scanner. Adds:
- hex decoding
- per-digit decimal point, blink and blank
- leading-zero suppression
- PWM brightness
- frame-synchronous input capture, so a display update never tears

Sits between game/timer logic and the board's segment/select pins.

---
 rtl/seg_scan_display.sv | 158 +++++++++++++++
 tb/tb_seg_scan_display.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed DIGITS-wide 7-segment scanner with hex decode,
// per-digit DP/blink/blank, leading-zero suppression, PWM brightness and frame-synchronous input capture.
`default_nettype none

module seg_scan_display #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   Digit_Data,
  input  logic [DIGITS-1:0]     DP_In,
  input  logic [DIGITS-1:0]     Blink_En,
  input  logic [DIGITS-1:0]     Blank_En,
  input  logic                  LZ_En,
  input  logic [3:0]            Bright,
  output logic [7:0]            Digitron_Out,
  output logic [DIGITS-1:0]     DigitronCS_Out,
  output logic                  Frame_Tick
);

  localparam int SUB_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_FRAMES - 1);

  logic [SUB_W-1:0]    sub_cnt;
  logic [2:0]          pwm_ph;
  logic [IDX_W-1:0]    idx;
  logic [FR_W-1:0]     frame_cnt;
  logic                blink_on;

  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blink;
  logic [DIGITS-1:0]   sh_blank;
  logic                sh_lz;

  logic                sub_wrap;
  logic                slot_wrap;
  logic                frame_wrap;

  assign sub_wrap   = (sub_cnt == SUB_LAST);
  assign slot_wrap  = sub_wrap && (pwm_ph == 3'd7);
  assign frame_wrap = slot_wrap && (idx == IDX_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sub_cnt   <= '0;
      pwm_ph    <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
      if (sub_wrap) pwm_ph <= pwm_ph + 1'b1;
      if (slot_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (frame_wrap) begin
        if (frame_cnt == FR_LAST) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Inputs are captured only at the frame boundary so one frame never mixes old and new data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_blink <= '0;
      sh_blank <= '1;
      sh_lz    <= 1'b0;
    end else if (frame_wrap) begin
      sh_data  <= Digit_Data;
      sh_dp    <= DP_In;
      sh_blink <= Blink_En;
      sh_blank <= Blank_En;
      sh_lz    <= LZ_En;
    end
  end

  logic [DIGITS-1:0] supp;
  logic              lz_run;

  always_comb begin
    supp   = '0;
    lz_run = sh_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lz_run && (sh_data[4*i +: 4] == 4'h0)) supp[i] = 1'b1;
      else lz_run = 1'b0;
    end
  end

  logic [3:0] code;
  logic [6:0] seg7;
  logic [3:0] bright_eff;
  logic       dark;

  assign code       = sh_data[{idx, 2'b00} +: 4];
  assign bright_eff = (Bright > 4'd8) ? 4'd8 : Bright;

  always_comb begin
    seg7 = 7'h00;
    case (code)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      4'hF: seg7 = 7'h71;
      default: seg7 = 7'h00;
    endcase
  end

  always_comb begin
    dark = sh_blank[idx] | supp[idx] | (sh_blink[idx] & ~blink_on) |
           ({1'b0, pwm_ph} >= bright_eff);
  end

  // Select and segments update on the same edge, so no other digit ever sees this pattern.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Digitron_Out   <= 8'h00;
      DigitronCS_Out <= '1;
      Frame_Tick     <= 1'b0;
    end else begin
      Frame_Tick <= frame_wrap;
      if (dark) begin
        Digitron_Out   <= 8'h00;
        DigitronCS_Out <= '1;
      end else begin
        Digitron_Out   <= {sh_dp[idx], seg7};
        DigitronCS_Out <= ~(DIGITS'(1) << idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed stimulus with a one-cycle-latency scoreboard of expected
// segment/select/tick values built from a cycle-position model of the scanner.
`default_nettype none

module tb_seg_scan_display;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int SLOT         = 8 * SCAN_DIV;
  localparam int FRAME        = SLOT * DIGITS;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] Digit_Data = '0;
  logic [3:0]  DP_In = '0;
  logic [3:0]  Blink_En = '0;
  logic [3:0]  Blank_En = '0;
  logic        LZ_En = 1'b0;
  logic [3:0]  Bright = 4'd8;
  logic [7:0]  Digitron_Out;
  logic [3:0]  DigitronCS_Out;
  logic        Frame_Tick;

  seg_scan_display #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .CLK(CLK), .RST(RST), .Digit_Data(Digit_Data), .DP_In(DP_In),
    .Blink_En(Blink_En), .Blank_En(Blank_En), .LZ_En(LZ_En), .Bright(Bright),
    .Digitron_Out(Digitron_Out), .DigitronCS_Out(DigitronCS_Out), .Frame_Tick(Frame_Tick)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] cs;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference scanner state: position within the frame plus shadowed inputs.
  int        k;
  int        fcnt;
  bit        blink_on;
  logic [15:0] sd;
  logic [3:0]  sdp, sbl, sbk;
  bit          slz;

  function automatic logic [6:0] dec(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    k = 0; fcnt = 0; blink_on = 1'b1;
    sd = '0; sdp = '0; sbl = '0; sbk = 4'hF; slz = 1'b0;
  endtask

  task automatic step();
    exp_t       e, got;
    int         idx, ph;
    logic [3:0] code, supp, be;
    bit         run, dark;
    idx = k / SLOT;
    ph  = (k / SCAN_DIV) % 8;
    supp = '0;
    run  = slz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (run && sd[4*i +: 4] == 4'h0) supp[i] = 1'b1;
      else run = 1'b0;
    end
    be   = (Bright > 4'd8) ? 4'd8 : Bright;
    code = sd[4*idx +: 4];
    dark = sbk[idx] || supp[idx] || (sbl[idx] && !blink_on) || (ph >= be);
    if (dark) begin
      e.seg = 8'h00;
      e.cs  = 4'hF;
    end else begin
      e.seg = {sdp[idx], dec(code)};
      e.cs  = ~(4'b0001 << idx);
    end
    e.ft = (k == FRAME - 1);
    q.push_back(e);

    @(posedge CLK);
    #1;
    if (k == FRAME - 1) begin
      sd = Digit_Data; sdp = DP_In; sbl = Blink_En; sbk = Blank_En; slz = LZ_En;
      if (fcnt == BLINK_FRAMES - 1) begin
        fcnt = 0;
        blink_on = !blink_on;
      end else begin
        fcnt++;
      end
    end
    k = (k + 1) % FRAME;

    got = q.pop_front();
    check("segments", Digitron_Out, got.seg);
    check("select", {4'h0, DigitronCS_Out}, {4'h0, got.cs});
    check("frame_tick", {7'h0, Frame_Tick}, {7'h0, got.ft});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Power-up reset
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check("reset_seg", Digitron_Out, 8'h00);
    check("reset_cs", {4'h0, DigitronCS_Out}, 8'h0F);
    check("reset_tick", {7'h0, Frame_Tick}, 8'h00);
    RST = 1'b0;

    // Plain decimal scan; first frame dark, then 1234
    Digit_Data = 16'h1234; Bright = 4'd8; LZ_En = 1'b0;
    run(3 * FRAME);

    // Asynchronous reset in the middle of digit 1's slot
    run(40);
    check("prereset_cs", {4'h0, DigitronCS_Out}, 8'h0D);
    check("prereset_seg", Digitron_Out, 8'h4F);
    #2 RST = 1'b1;
    #1;
    check("async_seg", Digitron_Out, 8'h00);
    check("async_cs", {4'h0, DigitronCS_Out}, 8'h0F);
    check("async_tick", {7'h0, Frame_Tick}, 8'h00);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    run(2 * FRAME);

    // Leading-zero suppression
    LZ_En = 1'b1; Digit_Data = 16'h0050;
    run(2 * FRAME);
    Digit_Data = 16'h0000;
    run(2 * FRAME);
    Digit_Data = 16'h0A0F;
    run(2 * FRAME);

    // Brightness
    LZ_En = 1'b0; Digit_Data = 16'h1234; Bright = 4'd3;
    run(2 * FRAME);
    Bright = 4'd0;
    run(FRAME);
    Bright = 4'd15;
    run(FRAME);

    // Blink on digit 0, DP on digit 1
    Bright = 4'd8; Blink_En = 4'b0001; DP_In = 4'b0010; Digit_Data = 16'h0000;
    run(6 * FRAME);

    // Mid-frame data change must not tear
    Blink_En = 4'b0000; DP_In = 4'b0000; Digit_Data = 16'h1111;
    run(2 * FRAME);
    run(50);
    Digit_Data = 16'h2222;
    run(FRAME - 50 + 2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
